// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_pkg
// Description : Shared width helpers and mode encoding for stream_popcount.
// Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    localparam logic c_mode_ones  = 1'b0;
    localparam logic c_mode_zeros = 1'b1;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int chunk_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int word_cnt_w(input int mem_bw);
        return $clog2(mem_bw) + 1;
    endfunction

    function automatic int acc_w(input int mem_bw, input int max_words);
        return $clog2(max_words * mem_bw) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_popcount.sv
`default_nettype none
// ============================================================================
// Module      : chunk_popcount
// Description : Combinational ones counter over one CHUNK_W-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_popcount
    import popcount_pkg::*;
#(
    parameter int CHUNK_W = 32
) (
    input  logic [CHUNK_W-1:0]                 chunk,
    output logic [chunk_cnt_w(CHUNK_W)-1:0]    cnt
);

    localparam int CNT_W = chunk_cnt_w(CHUNK_W);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            cnt = cnt + CNT_W'(chunk[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_popcount.sv
`default_nettype none
// ============================================================================
// Module      : stream_popcount
// Description : Two-stage streaming popcount with per-frame saturating total.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_popcount
    import popcount_pkg::*;
#(
    parameter int MEM_BW    = 128,
    parameter int CHUNK_W   = 32,
    parameter int MAX_WORDS = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [MEM_BW-1:0]                      in_word,
    input  logic                                   in_last,
    input  logic                                   in_mode,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [word_cnt_w(MEM_BW)-1:0]          out_word_cnt,
    output logic [acc_w(MEM_BW, MAX_WORDS)-1:0]    out_frame_cnt,
    output logic                                   out_last,
    output logic                                   out_sat
);

    localparam int NCHUNK = MEM_BW / CHUNK_W;
    localparam int CC_W   = chunk_cnt_w(CHUNK_W);
    localparam int WC_W   = word_cnt_w(MEM_BW);
    localparam int ACC_W  = acc_w(MEM_BW, MAX_WORDS);

    logic                w_en;
    logic                w_mode;
    logic [CC_W-1:0]     w_chunk_cnt [NCHUNK];
    logic [WC_W-1:0]     w_ones;
    logic [WC_W-1:0]     w_word_cnt;
    logic [ACC_W-1:0]    w_base;
    logic [ACC_W:0]      w_sum;
    logic                w_ovf;

    logic                r_first;
    logic                r_mode;
    logic                r_s1_valid;
    logic                r_s1_last;
    logic                r_s1_first;
    logic                r_s1_mode;
    logic [CC_W-1:0]     r_s1_cnt [NCHUNK];

    // Whole pipeline advances together; a full output stage stalls everything.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_mode   = r_first ? in_mode : r_mode;

    for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
        chunk_popcount #(
            .CHUNK_W (CHUNK_W)
        ) u_chunk (
            .chunk (in_word[k*CHUNK_W +: CHUNK_W]),
            .cnt   (w_chunk_cnt[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first    <= 1'b1;
            r_mode     <= c_mode_ones;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_mode  <= c_mode_ones;
            for (int k = 0; k < NCHUNK; k++) begin
                r_s1_cnt[k] <= '0;
            end
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_last  <= in_last;
                r_s1_first <= r_first;
                r_s1_mode  <= w_mode;
                r_first    <= in_last;
                if (r_first) begin
                    r_mode <= in_mode;
                end
                for (int k = 0; k < NCHUNK; k++) begin
                    r_s1_cnt[k] <= w_chunk_cnt[k];
                end
            end
        end
    end

    always_comb begin
        w_ones = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            w_ones = w_ones + WC_W'(r_s1_cnt[k]);
        end
    end

    // Extra sum bit flags overflow so the total clamps instead of wrapping.
    always_comb begin
        w_word_cnt = (r_s1_mode == c_mode_zeros) ? (WC_W'(MEM_BW) - w_ones) : w_ones;
        w_base     = r_s1_first ? '0 : out_frame_cnt;
        w_sum      = {1'b0, w_base} + (ACC_W+1)'(w_word_cnt);
        w_ovf      = w_sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_word_cnt  <= '0;
            out_frame_cnt <= '0;
            out_last      <= 1'b0;
            out_sat       <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_word_cnt  <= w_word_cnt;
                out_frame_cnt <= w_ovf ? '1 : w_sum[ACC_W-1:0];
                out_last      <= r_s1_last;
                out_sat       <= (r_s1_first ? 1'b0 : out_sat) | w_ovf;
            end
        end
    end

endmodule
`default_nettype wire
